// File: rtl/cpu_data_sink_if.sv
// Per-CPU 64-bit valid/ready beat stream between the multisim server and a sink.
// data[63:32] carries the CPU index, data[31:0] the sequence number.
interface cpu_data_sink_if;
    logic        data_vld;
    logic        data_rdy;
    logic [63:0] data;

    modport master (
        output data_vld,
        output data,
        input  data_rdy
    );

    modport slave (
        input  data_vld,
        input  data,
        output data_rdy
    );
endinterface

// File: rtl/cpu_data_sink.sv
// Server-side consumer for one CPU's beat stream. It applies LFSR-driven
// backpressure, checks CPU index, sequence order and handshake stability,
// counts accepted beats and flags completion after N_TRANSACTIONS beats.
module cpu_data_sink #(
    parameter int unsigned N_TRANSACTIONS = 1000,
    parameter int unsigned RDY_THROTTLE   = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           cpu_index,
    cpu_data_sink_if.slave        bus,
    output logic [31:0]           rx_count,
    output logic                  error,
    output logic [15:0]           error_count,
    output logic [63:0]           first_error_data,
    output logic                  transactions_done
);

    localparam logic [3:0]  THROTTLE  = 4'(RDY_THROTTLE);
    localparam logic [31:0] N_LIMIT   = 32'(N_TRANSACTIONS);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [31:0] exp_seq;
    logic        hold_pend;
    logic [63:0] hold_data;
    logic        xfer;
    logic        idx_bad;
    logic        seq_bad;
    logic        stab_bad;
    logic        any_fail;
    logic        last_beat;
    logic        rdy_next;

    // Next state, transfer detection, beat checks and next ready value.
    always_comb begin
        state_next = state;
        lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
        xfer       = (state == RUN) && bus.data_vld && bus.data_rdy;
        idx_bad    = xfer && (bus.data[63:32] != cpu_index);
        seq_bad    = xfer && (bus.data[31:0] != exp_seq);
        // A beat offered but not taken last cycle must be held unchanged.
        stab_bad   = (state != DONE) && hold_pend &&
                     (!bus.data_vld || (bus.data != hold_data));
        any_fail   = idx_bad || seq_bad || stab_bad;
        last_beat  = xfer && ((rx_count + 32'd1) == N_LIMIT);

        case (state)
            IDLE:    state_next = RUN;
            RUN:     if (rx_count == N_LIMIT) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase

        // Ready is only produced from RUN, so it first rises on the second
        // edge after reset release. It drops on the edge of the final
        // beat so no extra beat slips in before DONE is reached.
        rdy_next = 1'b0;
        if ((state == RUN) && (rx_count != N_LIMIT) && !last_beat) begin
            rdy_next = ({1'b0, lfsr[2:0]} >= THROTTLE);
        end
    end

    // State, LFSR, ready, stability history, counters and error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            lfsr             <= LFSR_SEED;
            bus.data_rdy     <= 1'b0;
            hold_pend        <= 1'b0;
            hold_data        <= '0;
            exp_seq          <= '0;
            rx_count         <= '0;
            error            <= 1'b0;
            error_count      <= '0;
            first_error_data <= '0;
        end else begin
            state        <= state_next;
            lfsr         <= lfsr_next;
            bus.data_rdy <= rdy_next;
            hold_pend    <= (state != DONE) && bus.data_vld && !bus.data_rdy;
            hold_data    <= bus.data;
            if (xfer) begin
                rx_count <= rx_count + 32'd1;
                exp_seq  <= bus.data[31:0] + 32'd1;
            end
            if (any_fail) begin
                error <= 1'b1;
                if (error_count != '1) begin
                    error_count <= error_count + 16'd1;
                end
                if (!error) begin
                    first_error_data <= bus.data;
                end
            end
        end
    end

    assign transactions_done = (state == DONE);

endmodule

// File: tb/tb_cpu_data_sink.sv
// Directed bench for cpu_data_sink: ordered stream, LFSR-throttled stream,
// index/sequence faults, handshake stability, mid-run reset and saturation.
module tb_cpu_data_sink;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    logic [31:0] cpu_index = 32'd3;

    logic [31:0] rx_a, rx_b, rx_c;
    logic        err_a, err_b, err_c;
    logic [15:0] ecnt_a, ecnt_b, ecnt_c;
    logic [63:0] first_a, first_b, first_c;
    logic        done_a, done_b, done_c;

    int n_chk  = 0;
    int n_fail = 0;

    cpu_data_sink_if bus_a ();
    cpu_data_sink_if bus_b ();
    cpu_data_sink_if bus_c ();

    cpu_data_sink #(.N_TRANSACTIONS(16), .RDY_THROTTLE(0)) dut_a (
        .clk(clk), .rst(rst_a), .cpu_index(cpu_index), .bus(bus_a),
        .rx_count(rx_a), .error(err_a), .error_count(ecnt_a),
        .first_error_data(first_a), .transactions_done(done_a)
    );

    cpu_data_sink #(.N_TRANSACTIONS(100), .RDY_THROTTLE(4), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .rst(rst_b), .cpu_index(cpu_index), .bus(bus_b),
        .rx_count(rx_b), .error(err_b), .error_count(ecnt_b),
        .first_error_data(first_b), .transactions_done(done_b)
    );

    cpu_data_sink #(.N_TRANSACTIONS(80000), .RDY_THROTTLE(0)) dut_c (
        .clk(clk), .rst(rst_c), .cpu_index(cpu_index), .bus(bus_c),
        .rx_count(rx_c), .error(err_c), .error_count(ecnt_c),
        .first_error_data(first_c), .transactions_done(done_c)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic reset_a();
        rst_a = 1'b1;
        bus_a.data_vld = 1'b0;
        bus_a.data = '0;
        tick();
        tick();
    endtask

    initial begin
        logic [15:0] m;
        logic        exp_rdy;
        logic        rdy_before;
        int          cnt;
        int          seq;
        bit          finished;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.data_vld = 1'b0; bus_a.data = '0;
        bus_b.data_vld = 1'b0; bus_b.data = '0;
        bus_c.data_vld = 1'b0; bus_c.data = '0;
        tick();
        tick();

        // Reset state
        chk("rst_rdy",   bus_a.data_rdy, 0);
        chk("rst_rx",    rx_a, 0);
        chk("rst_err",   err_a, 0);
        chk("rst_ecnt",  ecnt_a, 0);
        chk("rst_first", first_a, 0);
        chk("rst_done",  done_a, 0);

        // Ordered stream, no throttling, 16 beats
        rst_a = 1'b0;
        tick();
        chk("ord_rdy_e1", bus_a.data_rdy, 0);
        tick();
        chk("ord_rdy_e2", bus_a.data_rdy, 1);
        bus_a.data_vld = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus_a.data = {32'd3, 32'(i)};
            tick();
            chk("ord_rx", rx_a, 64'(i + 1));
        end
        chk("ord_rdy_last", bus_a.data_rdy, 0);
        chk("ord_done_early", done_a, 0);
        bus_a.data = {32'd3, 32'd16};
        tick();
        chk("ord_done", done_a, 1);
        chk("ord_rdy_done", bus_a.data_rdy, 0);
        tick();
        tick();
        tick();
        chk("ord_rx_hold", rx_a, 16);
        chk("ord_rdy_hold", bus_a.data_rdy, 0);
        chk("ord_err", err_a, 0);

        // Sequence and index faults
        reset_a();
        rst_a = 1'b0;
        tick();
        tick();
        bus_a.data_vld = 1'b1;
        bus_a.data = {32'd3, 32'd0}; tick();
        bus_a.data = {32'd3, 32'd1}; tick();
        chk("flt_ecnt0", ecnt_a, 0);
        bus_a.data = {32'd3, 32'd5}; tick();
        chk("flt_ecnt_seq", ecnt_a, 1);
        chk("flt_first", first_a, 64'h0000000300000005);
        bus_a.data = {32'd3, 32'd6}; tick();
        chk("flt_resync", ecnt_a, 1);
        bus_a.data = {32'd7, 32'd7}; tick();
        bus_a.data_vld = 1'b0;
        chk("flt_ecnt_idx", ecnt_a, 2);
        chk("flt_first_kept", first_a, 64'h0000000300000005);
        chk("flt_err", err_a, 1);
        chk("flt_rx", rx_a, 5);

        // Handshake stability: data changed, then valid dropped, while stalled
        reset_a();
        rst_a = 1'b0;
        bus_a.data_vld = 1'b1;
        bus_a.data = {32'd3, 32'd0};
        tick();
        bus_a.data = {32'd3, 32'd1};
        tick();
        chk("stb_ecnt1", ecnt_a, 1);
        chk("stb_err", err_a, 1);
        chk("stb_first", first_a, 64'h0000000300000001);
        bus_a.data_vld = 1'b0;
        tick();
        chk("stb_ecnt2", ecnt_a, 2);
        tick();
        chk("stb_ecnt_quiet", ecnt_a, 2);
        chk("stb_rx", rx_a, 0);

        // Reset mid-run
        reset_a();
        rst_a = 1'b0;
        tick();
        tick();
        bus_a.data_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_a.data = {32'd3, 32'(i)};
            tick();
        end
        chk("mid_rx5", rx_a, 5);
        rst_a = 1'b1;
        bus_a.data = {32'd3, 32'd5};
        tick();
        chk("mid_rdy", bus_a.data_rdy, 0);
        chk("mid_rx", rx_a, 0);
        chk("mid_err", err_a, 0);
        chk("mid_ecnt", ecnt_a, 0);
        chk("mid_first", first_a, 0);
        chk("mid_done", done_a, 0);
        rst_a = 1'b0;
        bus_a.data = {32'd3, 32'd0};
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            bus_a.data = {32'd3, 32'(i)};
            tick();
        end
        bus_a.data_vld = 1'b0;
        chk("mid_restart_rx", rx_a, 3);
        chk("mid_restart_err", err_a, 0);

        // Throttled stream against a reference LFSR
        m = 16'hACE1;
        exp_rdy = 1'b0;
        cnt = 0;
        seq = 0;
        finished = 1'b0;
        rst_b = 1'b0;
        bus_b.data_vld = 1'b1;
        bus_b.data = {32'd3, 32'd0};
        for (int k = 1; k <= 2000 && !finished; k++) begin
            rdy_before = exp_rdy;
            tick();
            if (rdy_before) begin
                cnt++;
                seq++;
            end
            exp_rdy = (k >= 2 && cnt < 100) ? m[2] : 1'b0;
            m = lfsr_step(m);
            chk("thr_rdy", bus_b.data_rdy, exp_rdy);
            bus_b.data = {32'd3, 32'(seq)};
            if (cnt == 100) finished = 1'b1;
        end
        chk("thr_count_reached", cnt, 100);
        chk("thr_rx", rx_b, 100);
        tick();
        chk("thr_done", done_b, 1);
        chk("thr_ecnt", ecnt_b, 0);
        bus_b.data_vld = 1'b0;

        // Error counter saturation
        rst_c = 1'b0;
        tick();
        tick();
        bus_c.data_vld = 1'b1;
        bus_c.data = {32'd9, 32'd0};
        tick();
        chk("sat_ecnt1", ecnt_c, 1);
        chk("sat_first", first_c, 64'h0000000900000000);
        for (int i = 1; i < 70000; i++) begin
            bus_c.data = {32'd9, 32'(i)};
            tick();
            if (i == 65534) chk("sat_ecnt_ffff", ecnt_c, 16'hFFFF);
        end
        bus_c.data_vld = 1'b0;
        chk("sat_ecnt_hold", ecnt_c, 16'hFFFF);
        chk("sat_first_kept", first_c, 64'h0000000900000000);
        chk("sat_rx", rx_c, 70000);
        chk("sat_done", done_c, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
